// File: rtl/if_fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC and issues one outstanding fetch at a time.
// Redirects may cancel the in-flight response; out-of-window or misaligned targets stop fetching until reset.
module if_fetch_sequencer #(
  parameter int unsigned         XLEN         = 32,
  parameter logic [XLEN-1:0]     IF_INC       = XLEN'(4),
  parameter logic [XLEN-1:0]     IF_BASE_ADDR = XLEN'(32'h1000_0000),
  parameter logic [XLEN-1:0]     IF_MAX_ADDR  = XLEN'(32'h1000_3FFF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            req_valid,
  output logic [XLEN-1:0] req_addr,
  input  logic            req_ready,
  input  logic            rsp_valid,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_o,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr
);

  localparam logic [XLEN-1:0] LAST_ADDR = IF_MAX_ADDR - XLEN'(3);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FAULT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] issued_pc_q, issued_pc_d;
  logic            drop_q, drop_d;
  logic            req_valid_q;
  logic            pc_valid_q, pc_valid_d;
  logic [XLEN-1:0] pc_o_q, pc_o_d;
  logic            fault_q;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;

  logic            issue_ok;
  logic            redir_legal;
  logic [XLEN-1:0] step_addr;

  assign issue_ok    = enable && !stall;
  assign redir_legal = (redirect_addr >= IF_BASE_ADDR) && (redirect_addr <= LAST_ADDR)
                       && (redirect_addr[1:0] == 2'b00);
  assign step_addr   = issued_pc_q + IF_INC;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    issued_pc_d  = issued_pc_q;
    drop_d       = drop_q;
    pc_valid_d   = 1'b0;
    pc_o_d       = pc_o_q;
    fault_addr_d = fault_addr_q;

    case (state_q)
      S_IDLE: begin
        if (issue_ok) state_d = S_REQ;
      end
      S_REQ: begin
        if (req_ready) begin
          issued_pc_d = pc_q;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_valid) begin
          state_d = issue_ok ? S_REQ : S_IDLE;
          // A redirect arriving with the response supersedes it, same as a pending drop.
          if (drop_q || redirect_valid) begin
            drop_d = 1'b0;
          end else begin
            pc_valid_d = 1'b1;
            pc_o_d     = issued_pc_q;
            if (step_addr > LAST_ADDR) begin
              state_d      = S_FAULT;
              fault_addr_d = step_addr;
            end else begin
              pc_d = step_addr;
            end
          end
        end
      end
      default: ;
    endcase

    if (redirect_valid && state_q != S_FAULT) begin
      if (!redir_legal) begin
        state_d      = S_FAULT;
        fault_addr_d = redirect_addr;
      end else begin
        pc_d = redirect_addr;
        // Mark the response of a request already accepted (this cycle or earlier) for discard.
        if ((state_q == S_REQ && req_ready) || (state_q == S_WAIT && !rsp_valid))
          drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= IF_BASE_ADDR;
      issued_pc_q  <= IF_BASE_ADDR;
      drop_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      pc_valid_q   <= 1'b0;
      pc_o_q       <= IF_BASE_ADDR;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      issued_pc_q  <= issued_pc_d;
      drop_q       <= drop_d;
      req_valid_q  <= (state_d == S_REQ);
      pc_valid_q   <= pc_valid_d;
      pc_o_q       <= pc_o_d;
      fault_q      <= (state_d == S_FAULT);
      fault_addr_q <= fault_addr_d;
    end
  end

  assign req_valid  = req_valid_q;
  assign req_addr   = pc_q;
  assign pc_valid   = pc_valid_q;
  assign pc_o       = pc_o_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_if_fetch_sequencer.sv
// Directed bench for if_fetch_sequencer: a cycle table for the main fetch flow,
// then hand-written sequences for fault and reset corner cases.
module tb_if_fetch_sequencer;

  localparam logic [31:0] B = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, stall, redirect_valid, req_ready, rsp_valid;
  logic [31:0] redirect_addr;
  logic        req_valid, pc_valid, fault;
  logic [31:0] req_addr, pc_o, fault_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_fetch_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .pc_valid(pc_valid), .pc_o(pc_o),
    .fault(fault), .fault_addr(fault_addr)
  );

  typedef struct {
    logic        en, st, rv;
    logic [31:0] ra;
    logic        rdy, rsp;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_pv;
    logic [31:0] e_pco;
    logic        e_f;
    logic [31:0] e_fa;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, st, rv, input logic [31:0] ra, input logic rdy, rsp,
                     input logic e_rv, input logic [31:0] e_ra, input logic e_pv,
                     input logic [31:0] e_pco, input logic e_f, input logic [31:0] e_fa);
    vec_t v;
    v.en = en; v.st = st; v.rv = rv; v.ra = ra; v.rdy = rdy; v.rsp = rsp;
    v.e_rv = e_rv; v.e_ra = e_ra; v.e_pv = e_pv; v.e_pco = e_pco; v.e_f = e_f; v.e_fa = e_fa;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the clock edge take them, then sample just after it.
  task automatic step(input logic en, st, rv, input logic [31:0] ra, input logic rdy, rsp);
    enable = en; stall = st; redirect_valid = rv; redirect_addr = ra;
    req_ready = rdy; rsp_valid = rsp;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0, 32'h0, 0, 0);
    step(0, 0, 0, 32'h0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rst_req_valid"},  {31'b0, req_valid}, 32'd0);
    check({tag, "_rst_req_addr"},   req_addr, B);
    check({tag, "_rst_pc_valid"},   {31'b0, pc_valid}, 32'd0);
    check({tag, "_rst_pc_o"},       pc_o, B);
    check({tag, "_rst_fault"},      {31'b0, fault}, 32'd0);
    check({tag, "_rst_fault_addr"}, fault_addr, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    enable = 0; stall = 0; redirect_valid = 0; redirect_addr = 0; req_ready = 0; rsp_valid = 0;

    //   en st rv ra              rdy rsp | rv  req_addr        pv  pc_o            f  fault_addr
    add(1, 0, 0, 32'h0,          1, 0,    1, B,              0, B,              0, 32'h0);
    add(1, 0, 0, 32'h0,          1, 0,    0, B,              0, B,              0, 32'h0);
    add(1, 0, 0, 32'h0,          1, 1,    1, B+32'h4,        1, B,              0, 32'h0);
    add(1, 0, 0, 32'h0,          1, 0,    0, B+32'h4,        0, B,              0, 32'h0);
    add(1, 0, 0, 32'h0,          1, 1,    1, B+32'h8,        1, B+32'h4,        0, 32'h0);
    add(1, 0, 0, 32'h0,          1, 0,    0, B+32'h8,        0, B+32'h4,        0, 32'h0);
    add(1, 0, 0, 32'h0,          1, 1,    1, B+32'hC,        1, B+32'h8,        0, 32'h0);
    // memory not ready for three cycles: request held stable
    add(1, 0, 0, 32'h0,          0, 0,    1, B+32'hC,        0, B+32'h8,        0, 32'h0);
    add(1, 0, 0, 32'h0,          0, 0,    1, B+32'hC,        0, B+32'h8,        0, 32'h0);
    add(1, 0, 0, 32'h0,          0, 0,    1, B+32'hC,        0, B+32'h8,        0, 32'h0);
    add(1, 0, 0, 32'h0,          1, 0,    0, B+32'hC,        0, B+32'h8,        0, 32'h0);
    // stall while waiting: response still delivered, no new request
    add(1, 1, 0, 32'h0,          1, 1,    0, B+32'h10,       1, B+32'hC,        0, 32'h0);
    add(1, 1, 0, 32'h0,          1, 0,    0, B+32'h10,       0, B+32'hC,        0, 32'h0);
    add(1, 0, 0, 32'h0,          1, 0,    1, B+32'h10,       0, B+32'hC,        0, 32'h0);
    add(1, 0, 0, 32'h0,          1, 0,    0, B+32'h10,       0, B+32'hC,        0, 32'h0);
    // redirect in WAIT: response for 0x10 dropped
    add(1, 0, 1, B+32'h100,      0, 0,    0, B+32'h100,      0, B+32'hC,        0, 32'h0);
    add(1, 0, 0, 32'h0,          0, 1,    1, B+32'h100,      0, B+32'hC,        0, 32'h0);
    add(1, 0, 0, 32'h0,          1, 0,    0, B+32'h100,      0, B+32'hC,        0, 32'h0);
    add(1, 0, 0, 32'h0,          1, 1,    1, B+32'h104,      1, B+32'h100,      0, 32'h0);
    // redirect in the same cycle as the response
    add(1, 0, 0, 32'h0,          1, 0,    0, B+32'h104,      0, B+32'h100,      0, 32'h0);
    add(1, 0, 1, B+32'h200,      0, 1,    1, B+32'h200,      0, B+32'h100,      0, 32'h0);
    // redirect in REQ without, then with, a handshake
    add(1, 0, 1, B+32'h300,      0, 0,    1, B+32'h300,      0, B+32'h100,      0, 32'h0);
    add(1, 0, 1, B+32'h400,      1, 0,    0, B+32'h400,      0, B+32'h100,      0, 32'h0);
    add(1, 0, 0, 32'h0,          0, 1,    1, B+32'h400,      0, B+32'h100,      0, 32'h0);
    add(1, 0, 0, 32'h0,          1, 0,    0, B+32'h400,      0, B+32'h100,      0, 32'h0);
    add(1, 0, 0, 32'h0,          1, 1,    1, B+32'h404,      1, B+32'h400,      0, 32'h0);
    // last word of the window, then step-out fault
    add(1, 0, 1, 32'h1000_3FFC,  0, 0,    1, 32'h1000_3FFC,  0, B+32'h400,      0, 32'h0);
    add(1, 0, 0, 32'h0,          1, 0,    0, 32'h1000_3FFC,  0, B+32'h400,      0, 32'h0);
    add(1, 0, 0, 32'h0,          1, 1,    0, 32'h1000_3FFC,  1, 32'h1000_3FFC,  1, 32'h1000_4000);
    add(1, 0, 1, B,              1, 1,    0, 32'h1000_3FFC,  0, 32'h1000_3FFC,  1, 32'h1000_4000);

    do_reset();
    check_reset_state("init");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].st, vecs[i].rv, vecs[i].ra, vecs[i].rdy, vecs[i].rsp);
      check($sformatf("v%0d_req_valid", i),  {31'b0, req_valid}, {31'b0, vecs[i].e_rv});
      check($sformatf("v%0d_req_addr", i),   req_addr, vecs[i].e_ra);
      check($sformatf("v%0d_pc_valid", i),   {31'b0, pc_valid}, {31'b0, vecs[i].e_pv});
      check($sformatf("v%0d_pc_o", i),       pc_o, vecs[i].e_pco);
      check($sformatf("v%0d_fault", i),      {31'b0, fault}, {31'b0, vecs[i].e_f});
      check($sformatf("v%0d_fault_addr", i), fault_addr, vecs[i].e_fa);
      $display("vec %0d: req_valid=%0b req_addr=%h pc_valid=%0b pc_o=%h fault=%0b fault_addr=%h",
               i, req_valid, req_addr, pc_valid, pc_o, fault, fault_addr);
    end

    // Misaligned redirect in IDLE: sticky fault, no requests even when enabled
    do_reset();
    check_reset_state("mis");
    step(0, 0, 1, 32'h1000_0102, 0, 0);
    check("mis_fault",      {31'b0, fault}, 32'd1);
    check("mis_fault_addr", fault_addr, 32'h1000_0102);
    check("mis_req_valid",  {31'b0, req_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 32'h0, 1, 1);
      check($sformatf("mis_hold%0d_req_valid", i), {31'b0, req_valid}, 32'd0);
      check($sformatf("mis_hold%0d_fault", i),     {31'b0, fault}, 32'd1);
      check($sformatf("mis_hold%0d_pc_valid", i),  {31'b0, pc_valid}, 32'd0);
    end
    $display("seq misaligned: fault=%0b fault_addr=%h", fault, fault_addr);

    // Reset restores fetching from base; out-of-window redirect while waiting
    do_reset();
    check("oow_rst_fault", {31'b0, fault}, 32'd0);
    step(1, 0, 0, 32'h0, 0, 0);
    check("oow_req_valid", {31'b0, req_valid}, 32'd1);
    check("oow_req_addr",  req_addr, B);
    step(1, 0, 0, 32'h0, 1, 0);
    step(1, 0, 1, 32'h2000_0000, 0, 0);
    check("oow_fault",      {31'b0, fault}, 32'd1);
    check("oow_fault_addr", fault_addr, 32'h2000_0000);
    check("oow_req_valid0", {31'b0, req_valid}, 32'd0);
    step(1, 0, 0, 32'h0, 1, 1);
    check("oow_no_pc_valid", {31'b0, pc_valid}, 32'd0);
    $display("seq out_of_window: fault=%0b fault_addr=%h", fault, fault_addr);

    // Below-base redirect in REQ
    do_reset();
    step(1, 0, 0, 32'h0, 0, 0);
    step(1, 0, 1, 32'h0FFF_FFFC, 0, 0);
    check("low_fault",      {31'b0, fault}, 32'd1);
    check("low_fault_addr", fault_addr, 32'h0FFF_FFFC);
    check("low_req_valid",  {31'b0, req_valid}, 32'd0);
    $display("seq below_base: fault=%0b fault_addr=%h", fault, fault_addr);

    // Reset mid-transaction: late response in IDLE ignored, then fetch restarts at base
    do_reset();
    step(1, 0, 0, 32'h0, 1, 0);
    step(1, 0, 0, 32'h0, 1, 0);
    rst = 1'b1;
    step(1, 0, 0, 32'h0, 0, 0);
    rst = 1'b0;
    check_reset_state("mid");
    step(0, 0, 0, 32'h0, 0, 1);
    check("late_pc_valid",  {31'b0, pc_valid}, 32'd0);
    check("late_req_valid", {31'b0, req_valid}, 32'd0);
    step(1, 0, 0, 32'h0, 1, 0);
    check("restart_req_valid", {31'b0, req_valid}, 32'd1);
    check("restart_req_addr",  req_addr, B);
    step(1, 0, 0, 32'h0, 1, 0);
    step(1, 0, 0, 32'h0, 0, 1);
    check("restart_pc_valid", {31'b0, pc_valid}, 32'd1);
    check("restart_pc_o",     pc_o, B);
    $display("seq reset_mid: pc_valid=%0b pc_o=%h", pc_valid, pc_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_sequencer.md
# if_fetch_sequencer

Instruction-fetch sequencer for the RV32 core: owns the program counter and drives one-outstanding-request fetches to instruction memory over a valid/ready request channel and a valid-only response channel. It sits between the pipeline control (enable, stall, branch/jump redirect) and the instruction memory port. It steps linearly through the fetch window `IF_BASE_ADDR..IF_MAX_ADDR` in `IF_INC` steps and flags out-of-window or misaligned targets as a sticky fault.

## Interface
- `XLEN`, 32: address width.
- `IF_INC`, 4: byte step between sequential fetches.
- `IF_BASE_ADDR`, 32'h1000_0000: reset PC and lowest legal fetch address.
- `IF_MAX_ADDR`, 32'h1000_3FFF: highest legal byte address. The last legal word is `IF_MAX_ADDR-3`.

Ports:
- `clk` in 1: core clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: fetching permitted.
- `stall` in 1: hold; no new request is issued while high.
- `redirect_valid` in 1: one-cycle pulse that loads a new PC.
- `redirect_addr` in XLEN: redirect target.
- `req_valid` out 1: fetch request valid.
- `req_addr` out XLEN: fetch address.
- `req_ready` in 1: memory accepts the request.
- `rsp_valid` in 1: memory returns data for the accepted request.
- `pc_valid` out 1: one-cycle pulse; the fetched word for `pc_o` is delivered downstream.
- `pc_o` out XLEN: address of the delivered word.
- `fault` out 1: sticky fetch fault.
- `fault_addr` out XLEN: offending address.

## Operation
- States:
  - IDLE: no request.
  - REQ: `req_valid=1`.
  - WAIT: one request accepted, awaiting `rsp_valid`.
  - FAULT: terminal until `rst`.
- Registers:
  - `pc`: next address to issue.
  - `issued_pc`: address of the accepted request.
  - `drop`: the outstanding response must be discarded.
- Transitions:
  - IDLE → REQ when `enable && !stall`.
  - REQ → WAIT on `req_valid && req_ready`. `issued_pc` ← `req_addr`.
  - WAIT → REQ on `rsp_valid` if `enable && !stall`, otherwise WAIT → IDLE.
  - Any state → FAULT on a fault condition.
- Sequential step: on a non-dropped response, `pc` ← `issued_pc + IF_INC`. If that result is greater than `IF_MAX_ADDR-3`, the response is still delivered and the block then enters FAULT with `fault_addr` = that result. There is no wrap-around.
- Redirect:
  - Legal target: `IF_BASE_ADDR <= addr <= IF_MAX_ADDR-3` and `addr[1:0]==0`. Otherwise FAULT, with `fault_addr=redirect_addr`.
  - In IDLE or REQ without a handshake: `pc` ← target. `req_addr` may change while `req_valid=1`; this is legal on this internal port.
  - In REQ with a handshake in the same cycle, or in WAIT: `pc` ← target and `drop` ← 1.
  - A dropped response produces no `pc_valid` and no PC step. `drop` clears when that response arrives.
  - Redirect in the same cycle as `rsp_valid` in WAIT: the response is dropped and the redirect wins.
- `stall` and `enable` only gate issue of new requests. They never cancel an accepted request.
- FAULT:
  - `req_valid=0`.
  - `rsp_valid` and `redirect_valid` are ignored.
  - `fault` holds 1 until `rst`.

## Timing
- Reset values: state IDLE, `pc=IF_BASE_ADDR`, `req_valid=0`, `req_addr=IF_BASE_ADDR`, `pc_valid=0`, `pc_o=IF_BASE_ADDR`, `fault=0`, `fault_addr=0`, `drop=0`.
- Reset asserted mid-transaction: all state is discarded the next cycle. A late `rsp_valid` arriving in IDLE is ignored.
- All outputs are registered.
- Issue latency:
  - `enable` rising in cycle t (IDLE, no stall) → `req_valid=1` at t+1.
  - A redirect at t → new `req_addr` visible at t+1.
- `rsp_valid` at t → `pc_valid=1` and `pc_o=issued_pc` at t+1. The next `req_valid` also appears at t+1 if permitted.
- Maximum throughput: one word per 2 cycles with a zero-wait-state memory (ready same cycle, response next cycle).
- `fault` rises the cycle after the fault condition is detected. `req_valid` is 0 in that same cycle.

## Test plan
- Reset then enable, with memory `req_ready=1` and response 1 cycle later → `pc_valid` pulses with `pc_o` = 0x1000_0000, 0x1000_0004, 0x1000_0008, each 2 cycles apart.
- Hold `req_ready=0` for 3 cycles → `req_valid` and `req_addr` stay stable. Assert `stall` in WAIT → the pending response is delivered, then no new request until `stall` is released.
- Redirect to 0x1000_0100 while in WAIT for 0x1000_0010 → the response for 0x1000_0010 is dropped (no `pc_valid`). The next request is 0x1000_0100, and the next `pc_o` is 0x1000_0100.
- Redirect to 0x1000_0102 (misaligned) or 0x2000_0000 (out of window) → `fault=1` with `fault_addr` equal to the target. `req_valid` stays 0 until `rst`. `rst` then restores a fetch from 0x1000_0000.
- Redirect to 0x1000_3FFC, then let it complete → `pc_valid` with `pc_o`=0x1000_3FFC, followed by `fault=1` with `fault_addr`=0x1000_4000 and no further requests.
- Redirect in the same cycle as `rsp_valid` → the response is dropped, and the next `req_addr` is the redirect target.
